// File: rtl/comb_check_pkg.sv
// Shared types and elaboration-time helpers for the combinational sweep checker.
// Imported by the checker top and its vector/settle counter.
package comb_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int MAX_N_IN = 6;

    // Width of a full truth table for an n-input function.
    function automatic int table_width(input int n);
        return 1 << n;
    endfunction

    // The settle counter only has to reach SETTLE-1; kept at least one bit wide.
    function automatic int settle_width(input int settle);
        int w;
        w = $clog2(settle + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sweep_counter.sv
// Vector counter with a per-vector settle sub-counter for the sweep checker.
// Produces the DUT input vector, a sample strike and a last-vector flag.
module sweep_counter
    import comb_check_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            settle_en,
    input  logic            sample_en,
    output logic [N_IN-1:0] vec,
    output logic            sample_strike,
    output logic            settle_done,
    output logic            last_vec
);

    localparam int SW = settle_width(SETTLE);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    logic [SW-1:0] settle_q;

    assign settle_done   = settle_en && (settle_q == SETTLE_LAST);
    assign sample_strike = sample_en;
    assign last_vec      = (vec == {N_IN{1'b1}});

    // Termination comes from the all-ones compare, so the counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec      <= '0;
            settle_q <= '0;
        end else if (clear) begin
            vec      <= '0;
            settle_q <= '0;
        end else begin
            if (settle_en) begin
                settle_q <= settle_done ? '0 : settle_q + 1'b1;
            end
            if (sample_en && !last_vec) begin
                vec <= vec + 1'b1;
            end
        end
    end

endmodule

// File: rtl/comb_sweep_checker.sv
// Self-running exhaustive sweep of a small combinational DUT: drives every input
// vector, captures the observed truth table and compares it with an expected one.
module comb_sweep_checker
    import comb_check_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [table_width(N_IN)-1:0] expected,
    input  logic                         y_in,
    output logic [N_IN-1:0]              vec_out,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [table_width(N_IN)-1:0] captured,
    output logic                         fail_valid,
    output logic [N_IN-1:0]              first_fail
);

    localparam int TW = table_width(N_IN);

    if (SETTLE < 1) begin : g_bad_settle
        $error("comb_sweep_checker: SETTLE must be >= 1");
    end
    if (N_IN < 1 || N_IN > MAX_N_IN) begin : g_bad_n_in
        $error("comb_sweep_checker: N_IN must be in 1..6");
    end

    state_t          state_q;
    state_t          state_d;
    logic [TW-1:0]   expected_q;
    logic            start_ok;
    logic            sample_strike;
    logic            settle_done;
    logic            last_vec;

    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

    sweep_counter #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_sweep_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (start_ok),
        .settle_en     (state_q == DRIVE),
        .sample_en     (state_q == SAMPLE),
        .vec           (vec_out),
        .sample_strike (sample_strike),
        .settle_done   (settle_done),
        .last_vec      (last_vec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)       state_d = DRIVE;
            DRIVE:   if (settle_done) state_d = SAMPLE;
            SAMPLE:  state_d = last_vec ? DONE : DRIVE;
            DONE:    if (start)       state_d = DRIVE;
            default: state_d = IDLE;
        endcase
    end

    // Only the first mismatch of a sweep is recorded in first_fail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            captured   <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            expected_q <= '0;
        end else if (start_ok) begin
            busy       <= 1'b1;
            done       <= 1'b0;
            captured   <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            expected_q <= expected;
        end else if (sample_strike) begin
            captured[vec_out] <= y_in;
            if ((y_in != expected_q[vec_out]) && !fail_valid) begin
                fail_valid <= 1'b1;
                first_fail <= vec_out;
            end
            if (last_vec) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    assign pass = done && (captured == expected_q);

endmodule

// File: tb/tb_comb_sweep_checker.sv
// Directed bench for comb_sweep_checker: a 3-input (SETTLE=1) and a 4-input (SETTLE=3)
// instance each drive a bench-modelled combinational function.
module tb_comb_sweep_checker;

    typedef struct {
        logic [15:0] cap;
        logic        pass;
        logic        fv;
        logic [3:0]  ff;
        int          cycles;
        int          n;
        int          s;
    } result_t;

    logic clk;
    logic rst_n;

    logic       start3, y3, busy3, done3, pass3, fv3;
    logic [7:0] exp3, cap3;
    logic [2:0] vec3, ff3;

    logic        start4, y4, busy4, done4, pass4, fv4;
    logic [15:0] exp4, cap4;
    logic [3:0]  vec4, ff4;

    logic        sel;
    logic [3:0]  obs_vec, obs_ff;
    logic [15:0] obs_cap;
    logic        obs_busy, obs_done, obs_pass, obs_fv;

    result_t sb_q[$];
    int checks;
    int failures;

    assign y3 = (vec3[2] & vec3[1]) | vec3[0];
    assign y4 = ^vec4;

    assign obs_vec  = sel ? vec4  : {1'b0, vec3};
    assign obs_ff   = sel ? ff4   : {1'b0, ff3};
    assign obs_cap  = sel ? cap4  : {8'h00, cap3};
    assign obs_busy = sel ? busy4 : busy3;
    assign obs_done = sel ? done4 : done3;
    assign obs_pass = sel ? pass4 : pass3;
    assign obs_fv   = sel ? fv4   : fv3;

    comb_sweep_checker #(.N_IN(3), .SETTLE(1)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start3),
        .expected   (exp3),
        .y_in       (y3),
        .vec_out    (vec3),
        .busy       (busy3),
        .done       (done3),
        .pass       (pass3),
        .captured   (cap3),
        .fail_valid (fv3),
        .first_fail (ff3)
    );

    comb_sweep_checker #(.N_IN(4), .SETTLE(3)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .expected   (exp4),
        .y_in       (y4),
        .vec_out    (vec4),
        .busy       (busy4),
        .done       (done4),
        .pass       (pass4),
        .captured   (cap4),
        .fail_valid (fv4),
        .first_fail (ff4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic modelY(input logic s, input int k);
        logic [3:0] v;
        v = k[3:0];
        return s ? ^v : ((v[2] & v[1]) | v[0]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Builds the expected sweep result from the bench's own function model.
    task automatic pushModel(input logic s, input logic [15:0] expv);
        result_t r;
        r.n = s ? 4 : 3;
        r.s = s ? 3 : 1;
        r.cap = '0;
        r.fv = 1'b0;
        r.ff = '0;
        for (int k = 0; k < (1 << r.n); k++) begin
            r.cap[k] = modelY(s, k);
            if (r.cap[k] != expv[k] && !r.fv) begin
                r.fv = 1'b1;
                r.ff = k[3:0];
            end
        end
        r.pass = !r.fv;
        r.cycles = (1 << r.n) * (r.s + 1);
        sb_q.push_back(r);
    endtask

    task automatic applyStimulus(input logic s, input logic [15:0] expv, input bit hold);
        @(negedge clk);
        sel = s;
        if (s) begin
            exp4 = expv;
            start4 = 1'b1;
        end else begin
            exp3 = expv[7:0];
            start3 = 1'b1;
        end
        pushModel(s, expv);
        @(negedge clk);
        if (!hold) begin
            start3 = 1'b0;
            start4 = 1'b0;
        end
    endtask

    // Entered at the falling edge just after the accepted start edge.
    task automatic checkOutput(input string tag);
        result_t r;
        int j;
        logic [15:0] mask;
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() == 0) return;
        r = sb_q[0];
        j = 0;
        while (!obs_done && j < 300) begin
            mask = '0;
            for (int k = 0; k < (1 << r.n); k++) begin
                if ((k + 1) * (r.s + 1) <= j) mask[k] = 1'b1;
            end
            chk({tag, "_vec"}, 32'(obs_vec), 32'(j / (r.s + 1)));
            chk({tag, "_busy"}, 32'(obs_busy), 32'd1);
            chk({tag, "_cap_partial"}, 32'(obs_cap), 32'(r.cap & mask));
            chk({tag, "_fv_partial"}, 32'(obs_fv),
                32'(r.fv && ((32'(r.ff) + 1) * (r.s + 1) <= j)));
            @(negedge clk);
            j++;
        end
        r = sb_q.pop_front();
        chk({tag, "_done_latency"}, 32'(j), 32'(r.cycles));
        chk({tag, "_captured"}, 32'(obs_cap), 32'(r.cap));
        chk({tag, "_pass"}, 32'(obs_pass), 32'(r.pass));
        chk({tag, "_fail_valid"}, 32'(obs_fv), 32'(r.fv));
        chk({tag, "_first_fail"}, 32'(obs_ff), 32'(r.ff));
        chk({tag, "_busy_end"}, 32'(obs_busy), 32'd0);
        chk({tag, "_vec_end"}, 32'(obs_vec), 32'((1 << r.n) - 1));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        sel = 1'b0;
        rst_n = 1'b0;
        start3 = 1'b0;
        start4 = 1'b0;
        exp3 = '0;
        exp4 = '0;

        #1;
        chk("reset_dut3", {busy3, done3, pass3, fv3, ff3, vec3, cap3}, 32'd0);
        chk("reset_dut4", {busy4, done4, pass4, fv4, ff4, vec4, cap4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 16'h00EA, 1'b0);
        checkOutput("s1_pass");

        applyStimulus(1'b0, 16'h00EB, 1'b0);
        checkOutput("s2_fail_v0");

        applyStimulus(1'b0, 16'h006A, 1'b0);
        checkOutput("s3_fail_v7");

        applyStimulus(1'b1, 16'h6996, 1'b0);
        checkOutput("s4_xor4");

        // Asynchronous reset in the middle of a clock phase, mid-sweep.
        sel = 1'b0;
        @(negedge clk);
        exp3 = 8'hEA;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (5) @(negedge clk);
        chk("s5_busy_before_rst", 32'(busy3), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_async_rst_dut3", {busy3, done3, pass3, fv3, ff3, vec3, cap3}, 32'd0);
        chk("s5_async_rst_dut4", {busy4, done4, pass4, fv4, ff4, vec4, cap4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h00EA, 1'b0);
        checkOutput("s5_after_rst");

        // start held high across a sweep and into DONE.
        applyStimulus(1'b0, 16'h00EA, 1'b1);
        checkOutput("s6_first");
        @(negedge clk);
        chk("s6_restart_done", 32'(done3), 32'd0);
        chk("s6_restart_pass", 32'(pass3), 32'd0);
        chk("s6_restart_cap", 32'(cap3), 32'd0);
        pushModel(1'b0, 16'h00EA);
        checkOutput("s6_second");
        start3 = 1'b0;
        @(negedge clk);
        chk("s6_held_done", 32'(done3), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comb_sweep_checker.md
Name: comb_sweep_checker

Overview:
Self-running stimulus and capture stage for small combinational blocks under test, such as 3- and 4-input single-output functions.
- Upstream side: drives every input vector in ascending binary order, MSB of the vector is the first DUT input.
- Downstream side: samples the DUT output for each vector and builds the observed truth table.
- Compares the observed table against an expected table and reports pass/fail plus the first failing vector.
- Replaces hand-written delay loops with a clocked, reusable checker.

Parameters:
N_IN, 4, number of DUT inputs; legal range 1..6.
SETTLE, 1, cycles each vector is held before sampling; must be >= 1, elaboration error otherwise.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a sweep; honoured only in IDLE or DONE
expected  input  2**N_IN  expected truth table; bit k = expected Y for vector k; latched on accepted start
y_in  input  1  DUT output
vec_out  output  N_IN  vector driven to DUT inputs
busy  output  1  high while a sweep is in progress
done  output  1  level; high in DONE until next accepted start or reset
pass  output  1  valid only when done; 1 iff captured equals the latched expected table
captured  output  2**N_IN  observed truth table; bit k = y_in sampled for vector k
fail_valid  output  1  a mismatch has been seen in the current or last sweep
first_fail  output  N_IN  lowest vector index that mismatched; 0 when fail_valid=0

Behaviour:
- Reset: while rst_n=0, every output is 0 and the state is IDLE. Reset acts immediately, asynchronously, including mid-sweep; a partial sweep is discarded.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, start=1 at edge e0:
  - clear captured, fail_valid and first_fail;
  - latch expected;
  - vec_out <= 0, busy <= 1;
  - go to DRIVE.
- DRIVE: hold vec_out for SETTLE cycles (internal settle counter), then go to SAMPLE.
- SAMPLE: one cycle; vec_out is still held. At the edge leaving SAMPLE:
  - captured[vec] <= y_in;
  - if y_in != expected_latched[vec] and fail_valid=0: fail_valid <= 1, first_fail <= vec. Later mismatches do not overwrite.
  - if vec == 2**N_IN-1: go to DONE, busy <= 0, done <= 1. vec_out holds its last value.
  - otherwise: vec <= vec+1, go to DRIVE.
- Timing per vector: SETTLE+1 cycles. Vector k is captured at edge e0+(k+1)(SETTLE+1). done rises immediately after edge e0+2**N_IN*(SETTLE+1).
- pass:
  - computed combinationally from a registered compare as done && (captured == expected_latched);
  - equivalently done && !fail_valid;
  - 0 whenever done=0.
- DONE: all results are held. start=1 restarts exactly as from IDLE; done and pass drop after that edge.
- start while busy is ignored. A new expected value while busy has no effect.
- The vector counter is N_IN bits wide and never wraps during a sweep. Termination is by the all-ones compare, not by overflow.
- No X-handling: y_in is sampled as-is.

Decomposition:
- Shared package comb_check_pkg holds:
  - state enum (IDLE, DRIVE, SAMPLE, DONE);
  - localparam function for table width 2**N_IN;
  - settle-counter width derived from SETTLE via $clog2(SETTLE+1).
- One natural sub-module, sweep_counter:
  - N_IN-bit vector counter with settle sub-counter;
  - outputs the vec value, a sample strike and a last-vector flag;
  - the FSM and compare logic stay in the top.

Test Plan:
1. N_IN=3, SETTLE=1, bench DUT Y=A&B|C, expected=8'hEA, pulse start.
   -> vec_out steps 0..7, each held 2 cycles; done rises 16 cycles after the start edge; captured=8'hEA, pass=1, fail_valid=0, first_fail=0.
2. Same DUT, expected=8'hEB.
   -> done after 16 cycles; pass=0, fail_valid=1, first_fail=3'd0, captured=8'hEA.
3. Same DUT, expected=8'h6A.
   -> fail_valid=1, first_fail=3'd7; fail_valid stays 0 until the vector-7 sample edge.
4. N_IN=4, SETTLE=3, DUT Y=A^B^C^D, expected=16'h6996.
   -> each vector held 4 cycles; done 64 cycles after start; captured=16'h6996, pass=1.
5. Scenario 1 config, rst_n driven low asynchronously mid-cycle 5 cycles after start.
   -> all outputs 0 within the same cycle without waiting for clk. After release, start gives a full 16-cycle sweep with correct results.
6. Scenario 1 config, start held high throughout.
   -> start is ignored while busy. In DONE the next edge restarts: captured clears, done drops for 16 cycles, then reasserts with identical results.
